// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and data access.
// Data has fixed priority; a starvation counter forces fetch and a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int unsigned WIDTH_MEM  = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_if_req,
    input  logic [WIDTH_MEM-1:0] i_pc_in,
    input  logic                 i_dm_req,
    input  logic                 i_dm_we,
    input  logic [WIDTH_MEM-1:0] i_alu_addr,
    input  logic [WIDTH_MEM-1:0] i_dm_wdata,
    output logic                 o_sel_mem,
    output logic                 o_mem_req,
    output logic [WIDTH_MEM-1:0] o_mem_addr,
    output logic                 o_mem_we,
    output logic [WIDTH_MEM-1:0] o_mem_wdata,
    input  logic                 i_mem_ready,
    input  logic [WIDTH_MEM-1:0] i_mem_rdata,
    output logic [WIDTH_MEM-1:0] o_rdata,
    output logic                 o_if_done,
    output logic                 o_dm_done,
    output logic                 o_err
);

    localparam logic [3:0] StarveMax   = 4'(STARVE_MAX);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [3:0]           starve_q, starve_d;
    logic [7:0]           wd_q, wd_d;
    logic                 sel_q, sel_d;
    logic                 mem_req_q, mem_req_d;
    logic [WIDTH_MEM-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic [WIDTH_MEM-1:0] wdata_q, wdata_d;
    logic [WIDTH_MEM-1:0] rdata_q, rdata_d;
    logic                 if_done_q, if_done_d;
    logic                 dm_done_q, dm_done_d;
    logic                 err_q, err_d;
    logic                 grant_dm, grant_if;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wd_d      = wd_q;
        sel_d     = sel_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        if_done_d = 1'b0;
        dm_done_d = 1'b0;
        err_d     = 1'b0;
        // Fetch wins only when data has starved it for STARVE_MAX consecutive grants.
        grant_dm  = i_dm_req && !((starve_q == StarveMax) && i_if_req);
        grant_if  = i_if_req && !grant_dm;

        case (state_q)
            StIdle: begin
                if (grant_dm) begin
                    sel_d     = 1'b1;
                    addr_d    = i_alu_addr;
                    we_d      = i_dm_we;
                    wdata_d   = i_dm_wdata;
                    mem_req_d = 1'b1;
                    wd_d      = '0;
                    state_d   = StBusy;
                    if (!i_if_req) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (grant_if) begin
                    sel_d     = 1'b0;
                    addr_d    = i_pc_in;
                    we_d      = 1'b0;
                    wdata_d   = '0;
                    mem_req_d = 1'b1;
                    wd_d      = '0;
                    starve_d  = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (i_mem_ready || (wd_q == TimeoutLast)) begin
                    mem_req_d = 1'b0;
                    dm_done_d = sel_q;
                    if_done_d = !sel_q;
                    err_d     = !i_mem_ready;
                    state_d   = StDone;
                    if (i_mem_ready && !we_q) begin
                        rdata_d = i_mem_rdata;
                    end
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            StDone: begin
                wd_d    = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            starve_q  <= '0;
            wd_q      <= '0;
            sel_q     <= 1'b0;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wd_q      <= wd_d;
            sel_q     <= sel_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            if_done_q <= if_done_d;
            dm_done_q <= dm_done_d;
            err_q     <= err_d;
        end
    end

    assign o_sel_mem   = sel_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_we    = we_q;
    assign o_mem_wdata = wdata_q;
    assign o_rdata     = rdata_q;
    assign o_if_done   = if_done_q;
    assign o_dm_done   = dm_done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, wait states, watchdog, starvation, reset.
// Inputs change 1 ns after the rising edge; outputs are sampled there as well.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] pc_in, alu_addr, dm_wdata, mem_rdata;
    logic        sel_mem, mem_req, mem_we, if_done, dm_done, err;
    logic [31:0] mem_addr, mem_wdata, rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .WIDTH_MEM (32),
        .STARVE_MAX(4),
        .TIMEOUT   (16)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_if_req   (if_req),
        .i_pc_in    (pc_in),
        .i_dm_req   (dm_req),
        .i_dm_we    (dm_we),
        .i_alu_addr (alu_addr),
        .i_dm_wdata (dm_wdata),
        .o_sel_mem  (sel_mem),
        .o_mem_req  (mem_req),
        .o_mem_addr (mem_addr),
        .o_mem_we   (mem_we),
        .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready),
        .i_mem_rdata(mem_rdata),
        .o_rdata    (rdata),
        .o_if_done  (if_done),
        .o_dm_done  (dm_done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        pc_in = 0; alu_addr = 0; dm_wdata = 0; mem_rdata = 0;
        tick(); tick();
        checks++;
        if ({sel_mem, mem_req, mem_we, if_done, dm_done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {sel_mem, mem_req, mem_we, if_done, dm_done, err});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h expected all 0",
                     mem_addr, mem_wdata, rdata);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL idle_no_req: mem_req=%b expected 0", mem_req);
        end
    endtask

    task automatic test_single_fetch();
        pc_in = 32'h100; if_req = 1;
        tick();
        checks++;
        if ({mem_req, sel_mem, mem_we} !== 3'b100 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_grant: req/sel/we=%b addr=%h expected 100 addr=00000100",
                     {mem_req, sel_mem, mem_we}, mem_addr);
        end
        mem_ready = 1; mem_rdata = 32'h2008_0005;
        tick();
        checks++;
        if ({if_done, dm_done, err, mem_req} !== 4'b1000) begin
            errors++;
            $display("FAIL fetch_done: if/dm/err/req=%b expected 1000",
                     {if_done, dm_done, err, mem_req});
        end
        checks++;
        if (rdata !== 32'h2008_0005) begin
            errors++; $display("FAIL fetch_rdata: got %h expected 20080005", rdata);
        end
        if_req = 0; mem_ready = 0;
        tick();
        checks++;
        if (if_done !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse_len: if_done=%b expected 0", if_done);
        end
    endtask

    task automatic test_store();
        dm_req = 1; dm_we = 1; alu_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({mem_req, sel_mem, mem_we} !== 3'b111 || mem_addr !== 32'h40
            || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_grant: req/sel/we=%b addr=%h wdata=%h expected 111 40 deadbeef",
                     {mem_req, sel_mem, mem_we}, mem_addr, mem_wdata);
        end
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick();
        checks++;
        if ({dm_done, if_done, err} !== 3'b100) begin
            errors++;
            $display("FAIL store_done: dm/if/err=%b expected 100", {dm_done, if_done, err});
        end
        checks++;
        if (rdata !== 32'h2008_0005) begin
            errors++; $display("FAIL store_rdata: got %h expected 20080005", rdata);
        end
        dm_req = 0; dm_we = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_wait_states();
        dm_req = 1; dm_we = 0; alu_addr = 32'h80;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0 || dm_done !== 1'b0)
            begin
                errors++;
                $display("FAIL wait_stable[%0d]: req=%b addr=%h we=%b done=%b expected 1 80 0 0",
                         i, mem_req, mem_addr, mem_we, dm_done);
            end
            if (i == 4) begin
                mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        checks++;
        if (dm_done !== 1'b1 || rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL wait_done: dm_done=%b rdata=%h expected 1 cafef00d", dm_done, rdata);
        end
        dm_req = 0; mem_ready = 0;
        tick();
        checks++;
        if (dm_done !== 1'b0) begin
            errors++; $display("FAIL wait_pulse_len: dm_done=%b expected 0", dm_done);
        end
    endtask

    task automatic test_watchdog();
        int n;
        dm_req = 1; dm_we = 0; alu_addr = 32'h200; mem_ready = 0;
        tick();
        n = 0;
        while (dm_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++; $display("FAIL wd_busy_cycles: got %0d expected 16", n);
        end
        checks++;
        if ({dm_done, err} !== 2'b11 || rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL wd_abort: dm_done/err=%b rdata=%h expected 11 cafef00d",
                     {dm_done, err}, rdata);
        end
        dm_req = 0;
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL wd_err_pulse: err=%b expected 0", err);
        end
        if_req = 1; pc_in = 32'h300; mem_ready = 1; mem_rdata = 32'h0000_0013;
        tick(); tick();
        checks++;
        if ({if_done, err} !== 2'b10 || rdata !== 32'h13) begin
            errors++;
            $display("FAIL wd_recover: if_done/err=%b rdata=%h expected 10 00000013",
                     {if_done, err}, rdata);
        end
        if_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_starvation();
        logic [5:0] exp_dm;
        int         n;
        exp_dm = 6'b101111;  // bit k = 1 for a data grant at arbitration k
        if_req = 1; dm_req = 1; dm_we = 0; pc_in = 32'h400; alu_addr = 32'h500;
        mem_ready = 1; mem_rdata = 32'h55;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(if_done || dm_done) && n < 10);
            checks++;
            if (dm_done !== exp_dm[k] || if_done !== !exp_dm[k]) begin
                errors++;
                $display("FAIL starve_order[%0d]: dm_done=%b if_done=%b expected dm_done=%b",
                         k, dm_done, if_done, exp_dm[k]);
            end
        end
        if_req = 0; dm_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        dm_req = 1; dm_we = 1; alu_addr = 32'h600; dm_wdata = 32'hA5A5_A5A5; mem_ready = 0;
        tick(); tick();
        rst_n = 0;
        tick();
        checks++;
        if ({sel_mem, mem_req, mem_we, if_done, dm_done, err} !== 6'b0
            || {mem_addr, mem_wdata, rdata} !== 96'b0) begin
            errors++;
            $display("FAIL rst_mid_busy: ctrl=%b addr=%h wdata=%h rdata=%h expected all 0",
                     {sel_mem, mem_req, mem_we, if_done, dm_done, err}, mem_addr, mem_wdata,
                     rdata);
        end
        rst_n = 1; dm_req = 0; dm_we = 0;
        tick();
        checks++;
        if ({dm_done, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL rst_no_done: dm_done/req=%b expected 00", {dm_done, mem_req});
        end
        if_req = 1; pc_in = 32'h700; mem_ready = 1; mem_rdata = 32'h77;
        tick(); tick();
        checks++;
        if (if_done !== 1'b1 || rdata !== 32'h77) begin
            errors++;
            $display("FAIL rst_then_fetch: if_done=%b rdata=%h expected 1 00000077",
                     if_done, rdata);
        end
        if_req = 0; mem_ready = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_wait_states();
        test_watchdog();
        test_starvation();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between instruction fetch (PC address) and data access (ALU-computed address).
- Drives the select of the existing PC/ALU address mux: 0 = PC, 1 = ALU address.
- Sits between the fetch stage, the load/store unit and the unified memory.
- Data access has fixed priority over fetch. A starvation counter guarantees fetch forward progress, and a watchdog aborts hung memory transactions.

Parameters:
- WIDTH_MEM, 32, address/data width.
- STARVE_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced (1..15).
- TIMEOUT, 16, maximum BUSY cycles waiting for i_mem_ready before abort (2..255).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_if_req  input  1  fetch request; level, held until o_if_done.
- i_pc_in  input  WIDTH_MEM  fetch address (PC).
- i_dm_req  input  1  data request; level, held until o_dm_done.
- i_dm_we  input  1  data write enable (1 = store).
- i_alu_addr  input  WIDTH_MEM  data address from ALU.
- i_dm_wdata  input  WIDTH_MEM  store data.
- o_sel_mem  output  1  mux select: 1 = ALU address, 0 = PC.
- o_mem_req  output  1  memory request strobe.
- o_mem_addr  output  WIDTH_MEM  registered memory address.
- o_mem_we  output  1  memory write enable.
- o_mem_wdata  output  WIDTH_MEM  registered store data.
- i_mem_ready  input  1  memory completes the current access this cycle.
- i_mem_rdata  input  WIDTH_MEM  read data, valid with i_mem_ready.
- o_rdata  output  WIDTH_MEM  latched read data for the requester.
- o_if_done  output  1  one-cycle fetch completion pulse.
- o_dm_done  output  1  one-cycle data completion pulse.
- o_err  output  1  one-cycle pulse with done on watchdog abort.

Behaviour:
- Reset (i_rst_n low at the rising edge):
  - State IDLE.
  - All outputs 0: o_sel_mem, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_rdata, o_if_done, o_dm_done, o_err.
  - Starvation counter 0, watchdog 0.
  - Reset mid-transaction aborts silently: no done pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE: arbitration happens each cycle.
  - Data is granted if i_dm_req=1, unless the starvation counter equals STARVE_MAX and i_if_req=1; in that case fetch is granted.
  - Otherwise fetch is granted if i_if_req=1.
  - On a grant: register o_sel_mem (1 = data, 0 = fetch), o_mem_addr (i_alu_addr or i_pc_in), o_mem_we (i_dm_we for data, 0 for fetch) and o_mem_wdata; go to BUSY.
  - No request: stay in IDLE; o_mem_req=0; o_sel_mem holds its last value.
- Starvation counter:
  - Increments on a data grant while i_if_req=1, saturating at STARVE_MAX.
  - Clears on a fetch grant, and on a data grant while i_if_req=0.
- BUSY:
  - o_mem_req=1; address, we and wdata are held stable.
  - Watchdog increments every BUSY cycle.
  - i_mem_ready=1: latch i_mem_rdata into o_rdata (for reads only; stores leave o_rdata unchanged), then go to DONE.
  - Watchdog reaches TIMEOUT-1 without ready: go to DONE with the error flag set; o_rdata is unchanged.
- DONE (exactly one cycle):
  - o_mem_req=0.
  - Pulse o_dm_done if o_sel_mem=1, else o_if_done.
  - o_err=1 if aborted.
  - Clear watchdog; return to IDLE.
  - The requester deasserts its req in the DONE cycle; the arbiter ignores requests in DONE.
- Latency:
  - Grant registers at the edge after IDLE sees the request.
  - Minimum transaction: 3 cycles (IDLE → BUSY with ready → DONE).
  - Back-to-back accesses: one access every 3 cycles minimum.
- Simultaneous fetch and data requests are resolved only by the priority rule; ties are never split across cycles.
- Requests that change while BUSY have no effect on the in-flight access.

Test Plan:
- Single fetch: i_pc_in=0x100, i_if_req=1, memory ready after 1 BUSY cycle with rdata 0x20080005 → o_sel_mem=0, o_mem_addr=0x100, o_if_done pulses at cycle 3, o_rdata=0x20080005.
- Store: i_dm_req=1, i_dm_we=1, i_alu_addr=0x40, i_dm_wdata=0xDEADBEEF → o_sel_mem=1, o_mem_we=1, o_mem_wdata=0xDEADBEEF, o_dm_done pulse, o_rdata unchanged.
- Simultaneous requests (if and dm both held, dm re-requests immediately after each done), STARVE_MAX=4 → grants in order: D, D, D, D, F, D…; fetch served on the 5th arbitration.
- Watchdog: data read, i_mem_ready held 0, TIMEOUT=16 → o_dm_done and o_err pulse together after 16 BUSY cycles; o_rdata unchanged; next arbitration proceeds normally.
- Wait states: ready arrives after 5 BUSY cycles → o_mem_addr and o_mem_we stable across all 5 cycles; done pulse exactly 1 cycle.
- Reset mid-BUSY: drive i_rst_n=0 for 1 cycle during an access → all outputs 0 next cycle, no done pulse, counter 0, FSM in IDLE.
